// File: rtl/vga_frame_sequencer_pkg.sv
// Shared types and constants for the VGA frame sequencer: FSM states,
// configuration bit positions and small helpers for the divider and palette.
package vga_seq_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } seq_state_e;

  localparam int CFG_SPEED_LSB = 0;
  localparam int CFG_DIR       = 2;
  localparam int CFG_PAUSE     = 3;
  localparam int CFG_PAL_LSB   = 4;
  localparam int CFG_MUTE      = 6;
  localparam int CFG_STEP      = 7;

  localparam logic [1:0] PAL_AUTO = 2'd3;

  // Last divider count before an advance: 1, 2, 4 or 8 frames per advance.
  function automatic logic [2:0] div_limit(input logic [1:0] speed);
    logic [2:0] lim;
    case (speed)
      2'd0:    lim = 3'd0;
      2'd1:    lim = 3'd1;
      2'd2:    lim = 3'd3;
      2'd3:    lim = 3'd7;
      default: lim = 3'd0;
    endcase
    return lim;
  endfunction

  // Auto-palette rotation 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] pal_next(input logic [1:0] pal);
    logic [1:0] nxt;
    case (pal)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      2'd2:    nxt = 2'd0;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_frame_sequencer_cfg_sync2.sv
// Two-flop synchroniser bringing the raw ui_in configuration pins into the
// pixel-clock domain; both stages clear to zero on reset.
module cfg_sync2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] meta_r;

  // Metastability-settling pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= 8'd0;
      q      <= 8'd0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/vga_frame_sequencer.sv
// Frame sequencer: advances the frame number on vsync rising edges at a
// programmable rate/direction, with pause, single-step and palette/audio control.
module vga_frame_sequencer
  import vga_seq_pkg::*;
#(
  parameter int SCENE_LEN = 64,
  parameter int FRAME_W   = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic [7:0]         cfg_in,
  output logic [FRAME_W-1:0] frame_no,
  output logic               frame_tick,
  output logic [1:0]         palette_sel,
  output logic               audio_en,
  output logic               paused
);

  localparam int SCENE_W = $clog2(SCENE_LEN + 1);
  localparam logic [SCENE_W-1:0] SCENE_LAST = SCENE_W'(SCENE_LEN - 1);
  localparam logic [SCENE_W-1:0] SCENE_ONE  = {{(SCENE_W-1){1'b0}}, 1'b1};
  localparam logic [FRAME_W-1:0] FRAME_ONE  = {{(FRAME_W-1){1'b0}}, 1'b1};

  logic [7:0]         cfg_s;
  logic [1:0]         speed_s;
  logic [1:0]         pal_s;
  logic               dir_s;
  logic               pause_s;
  logic               mute_s;
  logic               step_s;
  logic               vrise_s;
  logic               step_rise_s;
  logic               step_set_s;
  logic               adv_s;
  logic               consume_s;
  logic [2:0]         div_nxt_s;
  logic [FRAME_W-1:0] frame_nxt_s;
  seq_state_e         state_nxt_s;

  seq_state_e         state_r;
  logic               vsync_prev_r;
  logic               step_q_r;
  logic               step_pending_r;
  logic [1:0]         speed_prev_r;
  logic [2:0]         div_cnt_r;
  logic [SCENE_W-1:0] scene_cnt_r;

  cfg_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cfg_in),
    .q     (cfg_s)
  );

  assign speed_s     = cfg_s[CFG_SPEED_LSB +: 2];
  assign pal_s       = cfg_s[CFG_PAL_LSB +: 2];
  assign dir_s       = cfg_s[CFG_DIR];
  assign pause_s     = cfg_s[CFG_PAUSE];
  assign mute_s      = cfg_s[CFG_MUTE];
  assign step_s      = cfg_s[CFG_STEP];
  assign vrise_s     = vsync & ~vsync_prev_r;
  assign step_rise_s = step_s & ~step_q_r;
  assign step_set_s  = step_rise_s & ((state_r == ST_PAUSED) | pause_s);
  assign frame_nxt_s = dir_s ? (frame_no - FRAME_ONE) : (frame_no + FRAME_ONE);

  // Advance decision for a frame edge, evaluated with the config being committed.
  always_comb begin
    state_nxt_s = pause_s ? ST_PAUSED : ST_RUN;
    adv_s       = 1'b0;
    consume_s   = 1'b0;
    div_nxt_s   = div_cnt_r;
    if (speed_s != speed_prev_r) begin
      div_nxt_s = 3'd0;
    end else if (state_nxt_s == ST_RUN) begin
      if (div_cnt_r == div_limit(speed_s)) begin
        adv_s     = 1'b1;
        div_nxt_s = 3'd0;
      end else begin
        div_nxt_s = div_cnt_r + 3'd1;
      end
    end else begin
      adv_s     = step_pending_r;
      consume_s = step_pending_r;
    end
  end

  // Sequencer FSM, counters and registered outputs; all commits happen at vrise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_RUN;
      vsync_prev_r   <= 1'b1;
      step_q_r       <= 1'b0;
      step_pending_r <= 1'b0;
      speed_prev_r   <= 2'd0;
      div_cnt_r      <= 3'd0;
      scene_cnt_r    <= {SCENE_W{1'b0}};
      frame_no       <= {FRAME_W{1'b0}};
      frame_tick     <= 1'b0;
      palette_sel    <= 2'd0;
      audio_en       <= 1'b0;
      paused         <= 1'b0;
    end else begin
      vsync_prev_r <= vsync;
      step_q_r     <= step_s;
      frame_tick   <= 1'b0;
      if (vrise_s) begin
        state_r      <= state_nxt_s;
        paused       <= (state_nxt_s == ST_PAUSED);
        audio_en     <= ~mute_s;
        speed_prev_r <= speed_s;
        div_cnt_r    <= div_nxt_s;
        if (adv_s) begin
          frame_no   <= frame_nxt_s;
          frame_tick <= 1'b1;
        end
        if (pal_s != PAL_AUTO) begin
          palette_sel <= pal_s;
          scene_cnt_r <= {SCENE_W{1'b0}};
        end else if (adv_s) begin
          if (scene_cnt_r == SCENE_LAST) begin
            scene_cnt_r <= {SCENE_W{1'b0}};
            palette_sel <= pal_next(palette_sel);
          end else begin
            scene_cnt_r <= scene_cnt_r + SCENE_ONE;
          end
        end
        // A step arriving on the edge itself is kept for the next edge.
        if (step_set_s) begin
          step_pending_r <= 1'b1;
        end else if (consume_s || ((state_r == ST_PAUSED) && (state_nxt_s == ST_RUN))) begin
          step_pending_r <= 1'b0;
        end
      end else if (step_set_s) begin
        step_pending_r <= 1'b1;
      end
    end
  end

endmodule
